// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first A - B - Bin using one full-subtractor cell; ports clk, rst, start, A, B, Bin -> busy, done, Diff, Bout, V
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             V
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b, r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_br, r_am, r_bm, r_busy, r_done, r_bout, r_v;
  logic             w_d, w_br;
  assign w_d  = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br = (~r_a[0] & r_b[0]) | (~r_a[0] & r_br) | (r_b[0] & r_br);
  assign busy = r_busy;
  assign done = r_done;
  assign Diff = r_diff;
  assign Bout = r_bout;
  assign V    = r_v;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_diff  <= '0;
      r_cnt   <= '0;
      r_br    <= 1'b0;
      r_am    <= 1'b0;
      r_bm    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bout  <= 1'b0;
      r_v     <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_br    <= Bin;
            r_cnt   <= '0;
            r_am    <= A[WIDTH-1];
            r_bm    <= B[WIDTH-1];
            r_busy  <= 1'b1;
            r_state <= SUB;
          end else begin
            r_state <= IDLE;
          end
        end
        SUB: begin
          r_diff <= {w_d, r_diff[WIDTH-1:1]};
          r_a    <= r_a >> 1;
          r_b    <= r_b >> 1;
          r_br   <= w_br;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) begin
            // w_d is the result MSB on this final edge
            r_bout  <= w_br;
            r_v     <= (r_am ^ r_bm) & (r_am ^ w_d);
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed self-checking bench for serial_subtractor
module tb_serial_subtractor;
  logic       clk = 1'b0, rst = 1'b0, start = 1'b0, Bin = 1'b0;
  logic [3:0] A = '0, B = '0;
  logic       busy, done, Bout, V;
  logic [3:0] Diff;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  serial_subtractor #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Bin(Bin),
    .busy(busy), .done(done), .Diff(Diff), .Bout(Bout), .V(V)
  );
  function automatic logic [5:0] model(input int a, input int b, input int bin);
    int r, sa, sb, s;
    logic [3:0] d;
    r  = a - b - bin;
    sa = a > 7 ? a - 16 : a;
    sb = b > 7 ? b - 16 : b;
    s  = sa - sb - bin;
    d  = 4'(r);
    return {d, r < 0, s < -8 || s > 7};
  endfunction
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic bin,
                        output logic [3:0] d, output logic bo, output logic v,
                        output int lat, output int bc);
    @(negedge clk);
    A = a; B = b; Bin = bin; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = 4'($urandom); B = 4'($urandom); Bin = 1'($urandom);
    lat = 1; bc = 0;
    while (!done && lat < 20) begin
      if (busy) bc++;
      @(negedge clk);
      lat++;
    end
    d = Diff; bo = Bout; v = V;
  endtask
  task automatic test_reset();
    #2 rst = 1'b1;
    #1 checks++;
    if ({busy, done, Diff, Bout, V} !== 8'h00) begin
      failures++;
      $display("FAIL reset_async got=%h want=00", {busy, done, Diff, Bout, V});
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, Diff, Bout, V} !== 8'h00) begin
      failures++;
      $display("FAIL reset_hold got=%h want=00", {busy, done, Diff, Bout, V});
    end
    rst = 1'b0;
  endtask
  task automatic test_basic();
    logic [3:0] d; logic bo, v; int lat, bc;
    run_op(4'd9, 4'd3, 1'b0, d, bo, v, lat, bc);
    checks++;
    if ({8'(lat), 8'(bc), d, bo, v} !== {8'd5, 8'd4, 4'd6, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL basic lat=%0d busy=%0d diff=%0d bout=%b v=%b want lat=5 busy=4 diff=6 bout=0 v=1", lat, bc, d, bo, v);
    end
    @(negedge clk);
    checks++;
    if ({done, busy, Diff, Bout, V} !== {1'b0, 1'b0, 4'd6, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL result_hold got=%h want=%h", {done, busy, Diff, Bout, V}, {1'b0, 1'b0, 4'd6, 1'b0, 1'b1});
    end
  endtask
  task automatic test_extremes();
    logic [3:0] ta [3] = '{4'd3, 4'd0, 4'd7};
    logic [3:0] tb [3] = '{4'd5, 4'd0, 4'd8};
    logic       tn [3] = '{1'b0, 1'b1, 1'b0};
    logic [5:0] te [3] = '{{4'd14, 1'b1, 1'b0}, {4'd15, 1'b1, 1'b0}, {4'd15, 1'b1, 1'b1}};
    logic [3:0] d; logic bo, v; int lat, bc;
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], tn[i], d, bo, v, lat, bc);
      checks++;
      if ({8'(lat), 8'(bc), d, bo, v} !== {8'd5, 8'd4, te[i]}) begin
        failures++;
        $display("FAIL extreme_%0d lat=%0d busy=%0d res=%h want lat=5 busy=4 res=%h", i, lat, bc, {d, bo, v}, te[i]);
      end
    end
  endtask
  task automatic test_ignore_start();
    int lat, extra;
    @(negedge clk);
    A = 4'd12; B = 4'd4; Bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; A = 4'd1; B = 4'd1;
    @(negedge clk);
    start = 1'b0; A = 4'd3; B = 4'd9; Bin = 1'b1;
    lat = 3;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if ({8'(lat), Diff, Bout, V} !== {8'd5, 4'd8, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL ignore_start lat=%0d diff=%0d bout=%b v=%b want lat=5 diff=8 bout=0 v=0", lat, Diff, Bout, V);
    end
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (busy || done) extra++;
    end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL no_second_op active_cycles=%0d want 0", extra);
    end
  endtask
  task automatic test_back_to_back();
    logic [3:0] d; logic bo, v; int lat, bc, gap;
    run_op(4'd9, 4'd3, 1'b0, d, bo, v, lat, bc);
    checks++;
    if ({8'(lat), d} !== {8'd5, 4'd6}) begin
      failures++;
      $display("FAIL b2b_first lat=%0d diff=%0d want lat=5 diff=6", lat, d);
    end
    A = 4'd5; B = 4'd2; Bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = 4'd0; B = 4'd15;
    gap = 1;
    while (!done && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    checks++;
    if ({8'(gap), Diff, Bout, V} !== {8'd5, 4'd3, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL b2b_second gap=%0d diff=%0d bout=%b v=%b want gap=5 diff=3 bout=0 v=0", gap, Diff, Bout, V);
    end
  endtask
  task automatic test_reset_mid();
    logic [3:0] d; logic bo, v; int lat, bc, act;
    run_op(4'd7, 4'd8, 1'b0, d, bo, v, lat, bc);
    checks++;
    if ({d, bo, v} !== {4'd15, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL pre_reset_op res=%h want=%h", {d, bo, v}, {4'd15, 1'b1, 1'b1});
    end
    @(negedge clk);
    A = 4'd6; B = 4'd1; Bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1 checks++;
    if ({busy, done, Diff, Bout, V} !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid got=%h want=00", {busy, done, Diff, Bout, V});
    end
    act = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy || done) act++;
    end
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (busy || done) act++;
    end
    checks++;
    if (act !== 0) begin
      failures++;
      $display("FAIL reset_no_done active_cycles=%0d want 0", act);
    end
    run_op(4'd10, 4'd10, 1'b0, d, bo, v, lat, bc);
    checks++;
    if ({8'(lat), 8'(bc), d, bo, v} !== {8'd5, 8'd4, 6'd0}) begin
      failures++;
      $display("FAIL after_reset lat=%0d busy=%0d res=%h want lat=5 busy=4 res=00", lat, bc, {d, bo, v});
    end
  endtask
  task automatic test_exhaustive();
    int order [512];
    logic [3:0] d; logic bo, v; int lat, bc, j, t;
    logic [5:0] exp;
    for (int i = 0; i < 512; i++) order[i] = i;
    for (int i = 511; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < 512; i++) begin
      run_op(4'(order[i] >> 5), 4'(order[i] >> 1), order[i][0], d, bo, v, lat, bc);
      exp = model(order[i] >> 5 & 15, order[i] >> 1 & 15, order[i] & 1);
      checks++;
      if ({8'(lat), 8'(bc), d, bo, v} !== {8'd5, 8'd4, exp}) begin
        failures++;
        $display("FAIL exhaustive a=%0d b=%0d bin=%0d lat=%0d busy=%0d res=%h want lat=5 busy=4 res=%h",
                 order[i] >> 5, (order[i] >> 1) & 15, order[i] & 1, lat, bc, {d, bo, v}, exp);
      end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_exhaustive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
